// File: rtl/if_stage_if.sv
// Instruction-memory request/ready port between the fetch stage and instruction memory.
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (output imem_req, output imem_addr, input imem_rdata, input imem_ready);
  modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_ready);
endinterface

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage with IF/ID register: PC selection, wait-state tolerant fetch,
// wrong-path squashing on redirect/flush and a one-word skid buffer for stalls.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    PcSrc,
  input  logic [31:0]   adrOfBranch,
  input  logic [31:0]   Jadr,
  input  logic [31:0]   JrAdr,
  input  logic          Flush,
  input  logic          Stall,
  if_stage_if.master    imem,
  output logic [31:0]   Instruction,
  output logic [31:0]   pc,
  output logic          IFID_valid
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_HELD  = 2'd2;

  localparam logic [1:0] OP_HOLD   = 2'd0;
  localparam logic [1:0] OP_BUBBLE = 2'd1;
  localparam logic [1:0] OP_MEM    = 2'd2;
  localparam logic [1:0] OP_BUF    = 2'd3;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pend;
  logic [31:0] r_buf;
  logic [31:0] r_instr;
  logic [31:0] r_pcout;
  logic        r_valid;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;
  logic        w_redirect;
  logic        w_squash;
  logic [1:0]  w_state_next;
  logic [31:0] w_pc_next;
  logic [31:0] w_pend_next;
  logic [31:0] w_buf_next;
  logic [1:0]  w_ifid_op;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_redirect = (PcSrc != 2'b00) && !Stall;
  assign w_squash   = w_redirect || Flush;

  always_comb begin
    case (PcSrc)
      2'b01:   w_target = adrOfBranch;
      2'b10:   w_target = Jadr;
      2'b11:   w_target = JrAdr;
      default: w_target = w_pc_plus4;
    endcase
  end

  // PC stays on the fetch address through DRAIN, so it doubles as the held request address.
  assign imem.imem_req  = rst && (r_state != S_HELD);
  assign imem.imem_addr = r_pc;

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_pend_next  = r_pend;
    w_buf_next   = r_buf;
    w_ifid_op    = OP_HOLD;
    case (r_state)
      S_FETCH: begin
        if (imem.imem_ready) begin
          if (w_redirect) begin
            w_pc_next = w_target;
            w_ifid_op = OP_BUBBLE;
          end else if (Stall) begin
            w_pc_next    = w_pc_plus4;
            w_buf_next   = imem.imem_rdata;
            w_state_next = S_HELD;
          end else begin
            w_pc_next = w_pc_plus4;
            w_ifid_op = Flush ? OP_BUBBLE : OP_MEM;
          end
        end else if (w_redirect) begin
          w_pend_next  = w_target;
          w_ifid_op    = OP_BUBBLE;
          w_state_next = S_DRAIN;
        end else if (!Stall) begin
          w_ifid_op = OP_BUBBLE;
        end
      end
      S_DRAIN: begin
        if (w_redirect) w_pend_next = w_target;
        if (!Stall) w_ifid_op = OP_BUBBLE;
        // A redirect arriving on the completing edge is the latest and wins.
        if (imem.imem_ready) begin
          w_pc_next    = w_redirect ? w_target : r_pend;
          w_state_next = S_FETCH;
        end
      end
      S_HELD: begin
        if (!Stall) begin
          w_state_next = S_FETCH;
          if (w_squash) begin
            if (w_redirect) w_pc_next = w_target;
            w_ifid_op = OP_BUBBLE;
          end else begin
            w_ifid_op = OP_BUF;
          end
        end
      end
      default: w_state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_pend  <= 32'd0;
      r_buf   <= 32'd0;
      r_instr <= NOP_WORD;
      r_pcout <= 32'd0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_pend  <= w_pend_next;
      r_buf   <= w_buf_next;
      case (w_ifid_op)
        OP_BUBBLE: begin
          r_instr <= NOP_WORD;
          r_pcout <= 32'd0;
          r_valid <= 1'b0;
        end
        OP_MEM: begin
          r_instr <= imem.imem_rdata;
          r_pcout <= w_pc_plus4;
          r_valid <= 1'b1;
        end
        OP_BUF: begin
          r_instr <= r_buf;
          r_pcout <= r_pc;
          r_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign Instruction = r_instr;
  assign pc          = r_pcout;
  assign IFID_valid  = r_valid;

endmodule
